// File: rtl/jelly_data_shift_register_delay_pkg.sv
// Shared types and helpers for the stream sample-delay block.
package jelly_data_shift_register_delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num);
        return (sel > num) ? num : sel;
    endfunction

endpackage

// File: rtl/jelly_data_shift_register_delay_hist.sv
// Enable-shifted sample history with a read port at index d-1 (d==0 reads zero).
// JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN adds zero-init on reset/clear.
module jelly_data_shift_register_delay_hist
    import jelly_data_shift_register_delay_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = 5,
    parameter int unsigned NUM        = (1 << SEL_WIDTH) - 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter              DEVICE     = "RTL"
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [SEL_WIDTH-1:0]  sel_d,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [SEL_WIDTH-1:0] rd_idx;
    assign rd_idx = sel_d - 1'b1;

`ifndef JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN
    logic unused_ctrl;
    assign unused_ctrl = reset ^ clear;
`endif

    if (DEVICE == "RTL") begin : g_rtl
        logic [DATA_WIDTH-1:0] mem [NUM];

        always_ff @(posedge clk) begin
`ifdef JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN
            if (reset || clear) begin
                for (int unsigned i = 0; i < NUM; i++) mem[i] <= '0;
                if (!reset && shift) mem[0] <= s_data;
            end else
`endif
            if (shift) begin
                mem[0] <= s_data;
                for (int unsigned i = 1; i < NUM; i++) mem[i] <= mem[i-1];
            end
        end

        assign rd_data = (sel_d == '0) ? '0 : mem[rd_idx];
    end else begin : g_srl
        // Vendor targets: steer the un-reset history into addressable shift registers.
        (* shreg_extract = "yes", srl_style = "srl" *)
        logic [DATA_WIDTH-1:0] mem [NUM];

        always_ff @(posedge clk) begin
`ifdef JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN
            if (reset || clear) begin
                for (int unsigned i = 0; i < NUM; i++) mem[i] <= '0;
                if (!reset && shift) mem[0] <= s_data;
            end else
`endif
            if (shift) begin
                mem[0] <= s_data;
                for (int unsigned i = 1; i < NUM; i++) mem[i] <= mem[i-1];
            end
        end

        assign rd_data = (sel_d == '0) ? '0 : mem[rd_idx];
    end

endmodule

// File: rtl/jelly_data_shift_register_delay.sv
// Runtime-programmable stream sample delay with valid/ready handshake and fill tracking.
// Define JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN to emit flagged incomplete samples.
module jelly_data_shift_register_delay
    import jelly_data_shift_register_delay_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = 5,
    parameter int unsigned NUM        = (1 << SEL_WIDTH) - 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter              DEVICE     = "RTL"
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  clear,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_incomplete
);

    localparam int unsigned           FILL_WIDTH = $clog2(NUM + 1);
    localparam logic [FILL_WIDTH-1:0] FILL_MAX   = FILL_WIDTH'(NUM);

    state_t                state, state_next;
    logic [FILL_WIDTH-1:0] fill, fill_next;
    logic [SEL_WIDTH-1:0]  d;
    logic                  accept, full, complete, judge;
    logic [DATA_WIDTH-1:0] hist_data, out_data;

    assign d        = SEL_WIDTH'(clamp_sel(32'(sel), NUM));
    assign s_ready  = cke & ~reset & (~m_valid | m_ready);
    assign accept   = s_valid & s_ready;
    assign out_data = (d == '0) ? s_data : hist_data;

    jelly_data_shift_register_delay_hist #(
        .SEL_WIDTH  (SEL_WIDTH),
        .NUM        (NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .DEVICE     (DEVICE)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clear   (cke & clear),
        .shift   (accept),
        .s_data  (s_data),
        .sel_d   (d),
        .rd_data (hist_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            fill  <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
        end
    end

    always_comb begin
        fill_next = fill;
        if (cke) begin
            if (clear)
                fill_next = accept ? FILL_WIDTH'(1) : '0;
            else if (accept && fill != FILL_MAX)
                fill_next = fill + 1'b1;
        end
        state_next = (fill_next == FILL_MAX) ? FULL : FILL;
    end

    // A clear alongside an accept judges the sample against an empty history.
    always_comb begin
        full     = (state == FULL);
        complete = full | (32'(fill) >= 32'(d));
        judge    = clear ? (d == '0) : complete;
    end

`ifdef JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_incomplete <= 1'b0;
        end else if (cke) begin
            if (accept) begin
                m_valid      <= 1'b1;
                m_data       <= judge ? out_data : '0;
                m_incomplete <= ~judge;
            end else if (clear || m_ready) begin
                m_valid      <= 1'b0;
                m_incomplete <= 1'b0;
            end
        end
    end
`else
    assign m_incomplete = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (cke) begin
            if (accept) begin
                m_valid <= judge;
                m_data  <= out_data;
            end else if (clear || m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jelly_data_shift_register_delay.sv
// Self-checking bench for jelly_data_shift_register_delay against a queue-based history model.
module tb_jelly_data_shift_register_delay;
    import jelly_data_shift_register_delay_pkg::*;

    localparam int unsigned SEL_WIDTH  = 5;
    localparam int unsigned NUM        = 31;
    localparam int unsigned DATA_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset, cke, clear, s_valid, m_ready;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready, m_valid, m_incomplete;
    logic [DATA_WIDTH-1:0] m_data;

    int checks = 0;
    int errors = 0;

    logic [DATA_WIDTH-1:0] hist_q[$];
    logic                  exp_valid, exp_inc, exp_ready, exp_accept;
    logic [DATA_WIDTH-1:0] exp_data;

    jelly_data_shift_register_delay #(
        .SEL_WIDTH  (SEL_WIDTH),
        .NUM        (NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .DEVICE     ("RTL")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cke          (cke),
        .clear        (clear),
        .sel          (sel),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_incomplete (m_incomplete)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // History is the list of samples accepted since the last reset/clear, oldest first.
    task automatic model_edge();
        int unsigned           dd;
        bit                    ok;
        logic [DATA_WIDTH-1:0] smp;
        dd = (int'(sel) > NUM) ? NUM : int'(sel);
        if (reset) begin
            hist_q.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_inc   = 1'b0;
        end else if (cke) begin
            if (clear) hist_q.delete();
            if (exp_accept) begin
                ok  = hist_q.size() >= dd;
                smp = (dd == 0) ? s_data : (ok ? hist_q[hist_q.size() - dd] : '0);
`ifdef JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN
                exp_valid = 1'b1;
                exp_data  = ok ? smp : '0;
                exp_inc   = !ok;
`else
                exp_valid = ok;
                if (ok) exp_data = smp;
                exp_inc = 1'b0;
`endif
                hist_q.push_back(s_data);
                if (hist_q.size() > NUM) void'(hist_q.pop_front());
            end else if (clear || m_ready) begin
                exp_valid = 1'b0;
                exp_inc   = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        exp_ready = cke & ~reset & (~exp_valid | m_ready);
        check("s_ready", s_ready, exp_ready);
        exp_accept = s_valid & exp_ready;
        @(posedge clk);
        model_edge();
        #1;
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) check("m_data", m_data, exp_data);
        check("m_incomplete", m_incomplete, exp_inc);
        check("fill", dut.fill, hist_q.size());
        check("full_state", dut.state == FULL, hist_q.size() == NUM);
    endtask

    task automatic drive(input logic v, input logic [7:0] dat, input logic [4:0] s,
                         input logic mr, input logic clr = 1'b0,
                         input logic ce = 1'b1, input logic rst = 1'b0);
        s_valid = v;
        s_data  = dat;
        sel     = s;
        m_ready = mr;
        clear   = clr;
        cke     = ce;
        reset   = rst;
        cycle();
    endtask

    initial begin
        int accepted;
        int budget;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_inc   = 1'b0;
        s_valid = 1'b0; s_data = '0; sel = '0; m_ready = 1'b0;
        clear = 1'b0; cke = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        drive(1'b1, 8'h77, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_m_data", m_data, 0);

        // Fill/drop at sel=3
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 5'd3, 1'b1);
        drive(1'b0, 8'h00, 5'd3, 1'b1);
        drive(1'b0, 8'h00, 5'd3, 1'b1);

        // Zero delay
        drive(1'b1, 8'hA5, 5'd0, 1'b1);
        drive(1'b1, 8'h5A, 5'd0, 1'b1);
        drive(1'b0, 8'h00, 5'd0, 1'b1);

        // Backpressure at sel=1 over 20 samples
        accepted = 0;
        budget   = 0;
        while (accepted < 20 && budget < 200) begin
            drive(1'b1, 8'($urandom), 5'd1,
                  (budget < 3) ? 1'b1 : (budget < 8) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (exp_accept) accepted++;
            budget++;
        end
        check("bp_samples_accepted", accepted, 20);
        drive(1'b0, 8'h00, 5'd1, 1'b1);

        // Sel change and clamp, reaching FULL
        for (int i = 0; i < 31; i++) drive(1'b1, 8'($urandom), 5'd2, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 5'd7, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 5'd31, 1'b1);
        check("full_reached", dut.state == FULL, 1);

        // Clear with simultaneous accept
        drive(1'b1, 8'h11, 5'd0, 1'b1, 1'b1);
        check("clear_accept_data", m_data, 8'h11);
        drive(1'b1, 8'h22, 5'd1, 1'b1);
        check("after_clear_data", m_data, 8'h11);

        // cke=0 freeze mid-stream with clear and traffic attempted
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 5'd2, 1'b0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'($urandom), 5'd2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 5'd2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 5'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 63) == 0));

        // Reset pulse mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 5'd0, 1'b0);
        drive(1'b1, 8'h33, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_pulse_m_data", m_data, 0);
        drive(1'b1, 8'h44, 5'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jelly_data_shift_register_delay.md
Name: jelly_data_shift_register_delay

Overview:
- Stream-side successor to the shift-register LUT. Produces, for every accepted input sample, the sample accepted `sel` samples earlier.
- Uses a valid/ready handshake on both sides, so backpressure stalls the history shift.
- Tracks how much history has been filled, and drops (or flags) outputs whose history is incomplete.
- Sits in video/signal pipelines as a runtime-programmable sample delay (line/tap alignment).

Parameters:
- SEL_WIDTH, 5, width of the `sel` port.
- NUM, (1<<SEL_WIDTH)-1, history depth. Maximum delay is NUM samples.
- DATA_WIDTH, 8, sample width.
- DEVICE, "RTL", implementation hint. Behaviour must be identical for every value.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cke  input  1  clock enable. When 0, all state is frozen and s_ready=0.
- clear  input  1  synchronous history flush: fill count to 0, pending output dropped.
- sel  input  SEL_WIDTH  delay in samples. Sampled on each accepted input.
- s_data  input  DATA_WIDTH  input sample.
- s_valid  input  1  input valid.
- s_ready  output  1  input ready.
- m_data  output  DATA_WIDTH  delayed sample.
- m_valid  output  1  output valid.
- m_ready  input  1  output ready.
- m_incomplete  output  1  set when the emitted sample lacked history (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: m_valid=0, m_data=0, m_incomplete=0, fill count=0, state=FILL. History contents are don't-care.
- Delay clamp: d = min(sel, NUM).
- Readiness: s_ready = cke & ~reset & (~m_valid | m_ready). This is a combinational path from m_ready.
- Accept condition: s_valid & s_ready. On accept, in the same edge:
  - Output register loads: m_data <= (d==0 ? s_data : hist[d-1]).
  - History shifts: hist[0] <= s_data, hist[i] <= hist[i-1].
- Output validity on accept: m_valid <= (fill >= d), using the fill value before the accept.
- Fill count: fill <= min(fill+1, NUM).
- Latency: 1 cycle from accept to m_valid.
- Handshake: m_data and m_valid hold while m_valid & ~m_ready. If m_ready & m_valid and no accept, m_valid <= 0.
- State machine:
  - FILL: fill<NUM.
  - FULL: fill==NUM. In FULL every accept yields m_valid=1.
  - FILL->FULL on the accept that brings fill to NUM.
  - Any state->FILL on clear or reset.
- Incomplete samples (fill<d): consumed with no output, so m_valid=0 after that edge.
- Changing `sel` between samples is legal. Completeness is re-judged per sample against the current d; no flush is needed.
- Clear with a simultaneous accept: clear wins for the old history. The accepted sample enters as the first sample: fill=1, output judged with fill=0, so only d==0 yields m_valid.
- Clear without an accept: m_valid <= 0. The pending output is discarded even if m_ready=0.
- cke=0 and reset=0: no state changes, including clear, which is ignored.
- Reset mid-stream: everything returns to reset values in the next cycle, and the pending output is lost.

Optional Feature:
- Macro: JELLY_DATA_SHIFT_REGISTER_DELAY_INCOMPLETE_EN.
- When defined:
  - Incomplete samples are emitted rather than dropped: m_valid=1, m_incomplete=1, m_data=0.
  - History entries are zero-initialised on reset and on clear.
- When undefined:
  - Incomplete samples are dropped.
  - m_incomplete is constant 0.
  - History has no reset, which allows SRL inference.

Decomposition:
- Package jelly_data_shift_register_delay_pkg holds:
  - state enum {FILL, FULL};
  - helper function clamp_sel(sel, NUM).
- One natural sub-module: jelly_data_shift_register_delay_hist. It is the enable-shifted history array with a read port at index d-1, built with DEVICE/SRL awareness.
- The handshake, fill counter and FSM stay in the top module.

Test Plan:
- Fill/drop: reset; sel=3; stream 1,2,3,4,5 with m_ready=1.
  - Default: only 1,2 emitted, from inputs 4,5.
  - With the macro: 0,0,0,1,2 emitted, with m_incomplete=1,1,1,0,0.
- Zero delay: sel=0; inputs 0xA5,0x5A -> outputs 0xA5,0x5A, one cycle after each accept, with no drops.
- Backpressure: sel=1; m_ready=0 after the first output.
  - s_ready falls to 0 and m_data holds.
  - Release -> no sample lost or duplicated over 20 samples.
- Sel change and clamp: after 31 samples, switch sel 2->7, then sel=31 (NUM=31).
  - Each output equals the input d samples back; FULL is reached and no drops occur.
- Clear with simultaneous accept: after the FULL state, clear=1 together with input 0x11 at sel=0.
  - Output 0x11, fill=1; the next sample at sel=1 outputs 0x11.
- cke/reset: cke=0 for 5 cycles mid-stream -> all outputs frozen. Reset pulse -> m_valid=0 and the FILL state next cycle.
